// File: rtl/execute_mod.sv
// EX stage of the RV32I pipeline: operand forwarding, ALU, beq decision/target, EX/MEM register.
// Optional performance counters are enabled by defining EX_PERF_CNT_EN.
module execute_mod #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              ALUSrcE,
  input  logic              MemWriteE,
  input  logic              ResultSrcE,
  input  logic              BranchE,
  input  logic [2:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1E,
  input  logic [DATA_W-1:0] RD2E,
  input  logic [DATA_W-1:0] PCE,
  input  logic [DATA_W-1:0] PCPlus4E,
  input  logic [DATA_W-1:0] ImmExtE,
  input  logic [REG_AW-1:0] RdE,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [DATA_W-1:0] ResultW,
  output logic              PCSrcE,
  output logic [DATA_W-1:0] PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM,
  output logic [REG_AW-1:0] RdM,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] PCPlus4M
`ifdef EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  InstrCntE,
  output logic [CNT_W-1:0]  TakenCntE
`endif
);

  logic              reg_write_q, mem_write_q, result_src_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] alu_result_q, write_data_q, pc_plus4_q;

  logic [DATA_W-1:0] src_a, src_b, write_data_e, alu_result_e;
  logic              zero_e;

  // Select code 11 falls through to the register-file value, same as 00.
  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = alu_result_q;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   write_data_e = ResultW;
      2'b10:   write_data_e = alu_result_q;
      default: write_data_e = RD2E;
    endcase
    src_b = ALUSrcE ? ImmExtE : write_data_e;
  end

  always_comb begin
    alu_result_e = '0;
    case (ALUControlE)
      3'b000: alu_result_e = src_a + src_b;
      3'b001: alu_result_e = src_a - src_b;
      3'b010: alu_result_e = src_a & src_b;
      3'b011: alu_result_e = src_a | src_b;
      3'b100: alu_result_e = src_a << src_b[4:0];
      3'b101: alu_result_e = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      3'b110: alu_result_e = src_a ^ src_b;
      default: alu_result_e = '0;
    endcase
  end

  assign zero_e    = (alu_result_e == '0);
  assign PCSrcE    = BranchE & zero_e;
  assign PCTargetE = PCE + ImmExtE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
    end else begin
      reg_write_q  <= RegWriteE;
      mem_write_q  <= MemWriteE;
      result_src_q <= ResultSrcE;
      rd_q         <= RdE;
      alu_result_q <= alu_result_e;
      write_data_q <= write_data_e;
      pc_plus4_q   <= PCPlus4E;
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign RdM        = rd_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;

`ifdef EX_PERF_CNT_EN
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d, taken_cnt_q, taken_cnt_d;

  // Saturating counters: hold at all-ones rather than wrapping.
  always_comb begin
    instr_cnt_d = instr_cnt_q;
    taken_cnt_d = taken_cnt_q;
    if ((RegWriteE | MemWriteE | BranchE) && (instr_cnt_q != '1))
      instr_cnt_d = instr_cnt_q + 1'b1;
    if (PCSrcE && (taken_cnt_q != '1))
      taken_cnt_d = taken_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_cnt_q <= '0;
      taken_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign InstrCntE = instr_cnt_q;
  assign TakenCntE = taken_cnt_q;
`else
  // Counter width only matters when the counters are built.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule
